// File: rtl/pulse_bram_reader_pkg.sv
// pulse_bram_reader_pkg: shared FSM encoding and memory geometry for the pulse BRAM reader
package pulse_bram_reader_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, CLEAR, DONE} state_t;
  localparam int DEF_DEPTH = 2048;
  localparam int DEF_ADDR_STEP = 4;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
endpackage

// File: rtl/pulse_bram_reader.sv
// pulse_bram_reader: sweeps pin and pulse BRAMs, streams samples out, optionally clears behind itself
module pulse_bram_reader
  import pulse_bram_reader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_STEP = DEF_ADDR_STEP,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear_en,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   hit_count,
  output logic [31:0]      pin_addr,
  output logic [31:0]      pin_din,
  output logic             pin_we,
  output logic             pin_en,
  input  logic [31:0]      pin_dout,
  output logic [31:0]      pulse_addr,
  output logic [31:0]      pulse_din,
  output logic             pulse_we,
  output logic             pulse_en,
  input  logic [31:0]      pulse_dout,
  output logic [31:0]      m_data,
  output logic             m_pin,
  output logic [IDX_W-1:0] m_index,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic clr_q, last, acc, advance;
  logic [31:0] addr;
  logic unused_pin;
  assign unused_pin = ^pin_dout[31:1];
  assign last = idx == IDX_W'(DEPTH - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? READ : IDLE;
      READ:    state_n = WAIT;
      WAIT:    state_n = OUT;
      OUT:     state_n = !m_ready ? OUT : clr_q ? CLEAR : last ? DONE : READ;
      CLEAR:   state_n = last ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Both ports touch memory only in READ (read) and CLEAR (write zero); idle otherwise
  assign acc = state == READ || state == CLEAR;
  assign addr = acc ? 32'(idx) * 32'(ADDR_STEP) : '0;
  assign pin_addr = addr;
  assign pulse_addr = addr;
  assign pin_en = acc;
  assign pulse_en = acc;
  assign pin_we = state == CLEAR;
  assign pulse_we = state == CLEAR;
  assign pin_din = FP32_ZERO;
  assign pulse_din = FP32_ZERO;
  assign busy = state == READ || state == WAIT || state == OUT || state == CLEAR;
  assign done = state == DONE;
  assign m_valid = state == OUT;
  assign advance = (state == OUT && m_ready && !clr_q && !last) || (state == CLEAR && !last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      clr_q <= 1'b0;
      hit_count <= '0;
      m_data <= '0;
      m_pin <= 1'b0;
      m_index <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        idx <= '0;
        clr_q <= clear_en;
        hit_count <= '0;
      end
      if (advance) idx <= idx + 1'b1;
      if (state == WAIT) begin
        m_data <= pulse_dout;
        m_pin <= pin_dout[0];
        m_index <= idx;
        m_last <= last;
        if (pin_dout[0]) hit_count <= hit_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pulse_bram_reader.sv
// tb_pulse_bram_reader: directed frames against two 1-cycle-latency BRAM models
module tb_pulse_bram_reader;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, clear_en = 1'b0, m_ready = 1'b1;
  logic busy, done, pin_we, pin_en, pulse_we, pulse_en, m_pin, m_last, m_valid;
  logic [IDX_W:0] hit_count;
  logic [IDX_W-1:0] m_index;
  logic [31:0] pin_addr, pin_din, pulse_addr, pulse_din, m_data, pin_dout, pulse_dout;
  logic [31:0] pin_mem [DEPTH], pulse_mem [DEPTH], pin_init [DEPTH], pulse_init [DEPTH];
  logic ld = 1'b0;
  int checks = 0, errors = 0, beats, done_cyc, n_done;

  pulse_bram_reader #(.DEPTH(DEPTH), .ADDR_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en), .busy(busy), .done(done),
    .hit_count(hit_count), .pin_addr(pin_addr), .pin_din(pin_din), .pin_we(pin_we), .pin_en(pin_en),
    .pin_dout(pin_dout), .pulse_addr(pulse_addr), .pulse_din(pulse_din), .pulse_we(pulse_we),
    .pulse_en(pulse_en), .pulse_dout(pulse_dout), .m_data(m_data), .m_pin(m_pin), .m_index(m_index),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      pin_mem <= pin_init;
      pulse_mem <= pulse_init;
    end
    if (pin_en) begin
      if (pin_we) pin_mem[pin_addr[IDX_W+1:2]] <= pin_din;
      else pin_dout <= pin_mem[pin_addr[IDX_W+1:2]];
    end
    if (pulse_en) begin
      if (pulse_we) pulse_mem[pulse_addr[IDX_W+1:2]] <= pulse_din;
      else pulse_dout <= pulse_mem[pulse_addr[IDX_W+1:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: one pin at 5; 1: all pins set, pulse=i+1; 2: pins 0,7,15; 3: all zero
  task automatic preload(input int mode, input bit do_ld);
    for (int i = 0; i < DEPTH; i++) begin
      pin_init[i] = (mode == 1 || (mode == 2 && (i == 0 || i == 7 || i == 15))) ? 32'd1 : 32'd0;
      pulse_init[i] = mode == 1 ? 32'(i + 1) : mode == 2 ? 32'h4000_0000 + 32'(i) : 32'd0;
    end
    if (mode == 0) begin
      pin_init[5] = 32'd1;
      pulse_init[5] = 32'h3F59AD43;
    end
    if (do_ld) begin
      @(negedge clk);
      ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
    end
  endtask

  task automatic run_frame(input logic clr, input int stall_at, input int stall_len, input int restart_at,
                           input int abort_at);
    int cyc = 0, stall_cnt = 0;
    beats = 0;
    done_cyc = 0;
    n_done = 0;
    @(negedge clk);
    clear_en = clr;
    start = 1'b1;
    while (cyc < 400 && !(done_cyc != 0 && cyc > done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = cyc == restart_at;
      clear_en = ~clr;
      m_ready = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (m_valid && beats == abort_at) begin
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_index", 32'(m_index), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_en", {28'd0, pin_en, pulse_en, pin_we, pulse_we}, 32'd0);
        check("rst_addr", pin_addr | pulse_addr, 32'd0);
        clear_en = 1'b0;
        m_ready = 1'b1;
        return;
      end
      if (m_valid && beats == stall_at && stall_cnt < stall_len) begin
        m_ready = 1'b0;
        stall_cnt++;
        check("stall_index", 32'(m_index), 32'(stall_at));
        check("stall_data", m_data, pulse_init[stall_at]);
        check("stall_en", {30'd0, pin_en, pulse_en}, 32'd0);
      end else if (m_valid) begin
        if (beats < DEPTH) begin
          check("beat_index", 32'(m_index), 32'(beats));
          check("beat_data", m_data, pulse_init[beats]);
          check("beat_pin", 32'(m_pin), 32'(pin_init[beats][0]));
          check("beat_last", 32'(m_last), 32'(beats == DEPTH - 1));
        end else check("beat_overrun", 32'(beats), 32'(DEPTH - 1));
        beats++;
      end
    end
    clear_en = 1'b0;
  endtask

  initial begin
    int nz;
    #3 rst_n = 1'b0;
    #1;
    check("reset_busy_done_valid", {29'd0, busy, done, m_valid}, 32'd0);
    check("reset_hits", 32'(hit_count), 32'd0);
    check("reset_port", {30'd0, pin_en, pulse_en} | pin_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(0, 1);
    run_frame(1'b0, -1, 0, -1, -1);
    check("plain_beats", 32'(beats), 32'd16);
    check("plain_done_cycle", 32'(done_cyc), 32'd49);
    check("plain_done_count", 32'(n_done), 32'd1);
    check("plain_hits", 32'(hit_count), 32'd1);
    check("plain_not_cleared", pulse_mem[5], 32'h3F59AD43);

    preload(0, 1);
    run_frame(1'b1, -1, 0, -1, -1);
    check("clear_beats", 32'(beats), 32'd16);
    check("clear_done_cycle", 32'(done_cyc), 32'd65);
    check("clear_hits", 32'(hit_count), 32'd1);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) nz += int'(pin_mem[i] != 0) + int'(pulse_mem[i] != 0);
    check("clear_nonzero_words", 32'(nz), 32'd0);

    preload(3, 0);
    run_frame(1'b0, -1, 0, -1, -1);
    check("second_beats", 32'(beats), 32'd16);
    check("second_hits", 32'(hit_count), 32'd0);

    preload(0, 1);
    run_frame(1'b0, 3, 7, -1, -1);
    check("stall_beats", 32'(beats), 32'd16);
    check("stall_done_cycle", 32'(done_cyc), 32'd56);
    check("stall_hits", 32'(hit_count), 32'd1);

    preload(0, 1);
    run_frame(1'b0, -1, 0, 20, -1);
    check("restart_beats", 32'(beats), 32'd16);
    check("restart_done_count", 32'(n_done), 32'd1);
    check("restart_done_cycle", 32'(done_cyc), 32'd49);

    preload(1, 1);
    run_frame(1'b1, -1, 0, -1, 8);
    nz = 0;
    for (int i = 0; i < 8; i++) nz += int'(pin_mem[i] != 0) + int'(pulse_mem[i] != 0);
    check("abort_cleared_low", 32'(nz), 32'd0);
    nz = 0;
    for (int i = 8; i < DEPTH; i++) nz += int'(pin_mem[i] != 0) + int'(pulse_mem[i] != 0);
    check("abort_kept_high", 32'(nz), 32'd16);
    @(negedge clk);
    rst_n = 1'b1;

    preload(2, 1);
    run_frame(1'b0, -1, 0, -1, -1);
    check("pins3_beats", 32'(beats), 32'd16);
    check("pins3_hits", 32'(hit_count), 32'd3);
    check("pins3_done_cycle", 32'(done_cyc), 32'd49);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_bram_reader.md
# pulse_bram_reader

Read-side counterpart of the pulse generator. On each `start` it sweeps the pin BRAM and the pulse BRAM over the same word addresses, from 0 to DEPTH-1. Each fp32 pulse sample is sent downstream with its pin flag over a valid/ready stream. When enabled, each location is cleared to zero after it is consumed, so the generator's next frame accumulates from a clean memory. The block sits between the two BRAMs' second ports and the downstream consumer (DMA or AXI-stream packer).

## Interface
Parameters:
- `DEPTH`, 2048: number of 32-bit words swept per frame; a power of two.
- `ADDR_STEP`, 4: byte-address increment per word.
- `IDX_W`, $clog2(DEPTH): index width.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: frame request, sampled only in IDLE.
- `clear_en` input 1: write zero after read; latched at frame start.
- `busy` output 1: high from the cycle after start is accepted until DONE.
- `done` output 1: one-cycle pulse at frame end.
- `hit_count` output IDX_W+1: number of samples with pin bit0 = 1 in the last frame.
- `pin_addr` output 32, `pin_din` output 32, `pin_we` output 1, `pin_en` output 1: pin BRAM port.
- `pin_dout` input 32: pin BRAM read data.
- `pulse_addr` output 32, `pulse_din` output 32, `pulse_we` output 1, `pulse_en` output 1: pulse BRAM port.
- `pulse_dout` input 32: pulse BRAM read data.
- `m_data` output 32: fp32 pulse sample.
- `m_pin` output 1: pin flag, equal to pin_dout[0].
- `m_index` output IDX_W: word index of the sample.
- `m_last` output 1: high with index DEPTH-1.
- `m_valid` output 1: stream valid.
- `m_ready` input 1: stream ready.

## Operation
- FSM states: IDLE, READ, WAIT, OUT, CLEAR, DONE.
- IDLE: start=1 → READ. On that edge: idx=0, clear_en latched, hit_count=0.
- READ: pin_en=pulse_en=1, we=0, both addresses = idx*ADDR_STEP → WAIT.
- WAIT: en=0. The BRAM presents data. On exit, capture pulse_dout→m_data, pin_dout[0]→m_pin, idx→m_index, (idx==DEPTH-1)→m_last. Increment hit_count if pin bit set → OUT.
- OUT: m_valid=1. The payload is stable until m_valid&&m_ready on a rising edge.
  - On transfer with clear latched → CLEAR.
  - On transfer without clear, at last index → DONE.
  - On transfer without clear, otherwise → READ with idx+1.
- CLEAR: both ports en=1, we=1, din=0, same address as the read. Next state DONE if last, else READ with idx+1.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- start is ignored outside IDLE. clear_en changes mid-frame have no effect.
- Address arithmetic: idx is IDX_W bits, zero-extended to 32 and multiplied by ADDR_STEP. idx never wraps inside a frame; the last index ends the sweep.
- hit_count holds its value after DONE until the next accepted start.
- Reset (any state, asynchronous): state=IDLE. All outputs 0: addr, din, we, en, m_*, busy, done, hit_count. A frame in progress is abandoned with no partial clear beyond already-completed CLEAR cycles.
- The generator and the reader must not access the BRAMs at the same time. Software starts the reader only with the generator's cps=0. The block does no arbitration.

## Timing
- BRAM read latency is 1 cycle: data is valid in the cycle after en=1, we=0.
- start high at edge k: busy=1 and READ from k+1, WAIT at k+2, first m_valid=1 at k+3.
- Per-sample period with m_ready held high: 4 cycles with clear, 3 without.
- Full frame, ready high, no clear: done pulse 3·DEPTH+1 cycles after start is accepted. With clear: 4·DEPTH+1.
- Back-pressure: m_valid stays high with a constant payload for any number of m_ready=0 cycles. No BRAM access occurs while stalled.
- start and reset deasserting on the same edge: start is not seen until the first edge with rst_n=1.

## Structure
- Shared package holds:
  - FSM state enum.
  - Default DEPTH and ADDR_STEP, shared with the generator, which writes at lfsr*4 over 2048 words.
  - fp32 zero constant 32'h0000_0000.
- No sub-module is required. An optional `bram_rd_port` sub-module (read-and-optional-clear sequencer for one port) is natural if a third memory is added.

## Test plan
- Preload pulse[5]=32'h3F59AD43, pin[5]=1, all else 0; DEPTH=16, clear_en=0, m_ready=1 → 16 beats. Beat 5 carries data 3F59AD43 with m_pin=1. Beat 15 has m_last=1. hit_count=1. done at cycle 49.
- Same preload with clear_en=1 → same stream, done at cycle 65. Both BRAMs all zero afterwards. A second frame gives hit_count=0.
- m_ready held low for 7 cycles at beat 3 → m_valid high, m_data/m_index=3 constant for the whole stall. No en pulses during the stall.
- start pulsed again during busy → ignored. Exactly one done. Beat count stays 16.
- rst_n=0 asserted asynchronously at beat 8 (state OUT) → every output 0 immediately. Restart from idx 0 after start. Words 0..7 already zero if clear was on.
- Pins at indices 0, 7, 15 set → hit_count=3. The index-0 beat comes first, the index-15 beat last with m_last=1.
